// File: rtl/seq_det_sched.sv
// Round-robin front end sharing one bit-serial sequence detector among NREQ requesters.
// Each granted word is cleared into, shifted through and drained out of the detector.
module seq_det_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int DET_LAT = 2,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    det_clr,
    output logic                    det_inp,
    input  logic                    det_outp,
    output logic                    res_valid,
    output logic [IDW-1:0]          res_id,
    output logic [CW-1:0]           res_count,
    input  logic                    res_ready
);

    localparam int KW = $clog2(WIDTH + DET_LAT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, RESULT} state_t;

    state_t           state;
    state_t           next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   id;
    logic             found;
    logic             sample;
    logic [WIDTH-1:0] word;
    logic [KW-1:0]    k;
    logic [CW-1:0]    hit;

    // First valid requester at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            automatic int j = (int'(ptr) + i) % NREQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end

    always_comb begin
        next      = state;
        req_ready = '0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready = NREQ'(1) << win;
                    next      = CLEAR;
                end
            end
            CLEAR:
                next = SHIFT;
            SHIFT: begin
                if (k == KW'(WIDTH - 1))
                    next = (DET_LAT == 0) ? RESULT : DRAIN;
            end
            DRAIN: begin
                if (k == KW'(WIDTH + DET_LAT - 1))
                    next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready)
                    next = IDLE;
            end
            default:
                next = IDLE;
        endcase
    end

    // Response to bit k arrives DET_LAT cycles later, so the window is offset.
    assign sample = (state == SHIFT || state == DRAIN) && (k >= KW'(DET_LAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            id      <= '0;
            word    <= '0;
            k       <= '0;
            hit     <= '0;
            det_clr <= 1'b0;
            det_inp <= 1'b0;
        end else begin
            state   <= next;
            det_clr <= (next == CLEAR);
            det_inp <= (next == SHIFT) ? word[WIDTH-1] : 1'b0;
            if (state == IDLE && found) begin
                word <= req_data[int'(win)*WIDTH +: WIDTH];
                id   <= win;
                ptr  <= IDW'((int'(win) + 1) % NREQ);
            end else if (next == SHIFT) begin
                word <= word << 1;
            end
            if (state == CLEAR) begin
                k   <= '0;
                hit <= '0;
            end else if (state == SHIFT || state == DRAIN) begin
                k <= k + KW'(1);
                if (sample && det_outp && hit < CW'(WIDTH))
                    hit <= hit + CW'(1);
            end
        end
    end

    assign res_id    = id;
    assign res_count = hit;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: drives requesters, models the attached detector,
// and predicts grants and hit counts from round-robin and pair-detection rules.
module tb_seq_det_sched;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int DET_LAT = 2;
    localparam int IDW     = 2;
    localparam int CW      = 4;
    localparam int LAT     = WIDTH + DET_LAT + 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  det_clr;
    logic                  det_inp;
    logic                  det_outp;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [CW-1:0]         res_count;
    logic                  res_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ptr_m = 0;

    seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DET_LAT(DET_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .det_clr(det_clr), .det_inp(det_inp), .det_outp(det_outp),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached detector: non-overlapping pairs of equal bits, history starts as '0'.
    logic d_has, d_prev, d_s1, d_s2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || det_clr) begin
            d_has <= 1'b1; d_prev <= 1'b0; d_s1 <= 1'b0; d_s2 <= 1'b0;
        end else begin
            if (d_has && det_inp == d_prev) begin
                d_s1 <= 1'b1; d_has <= 1'b0;
            end else begin
                d_s1 <= 1'b0; d_has <= 1'b1; d_prev <= det_inp;
            end
            d_s2 <= d_s1;
        end
    end
    assign det_outp = d_s2;

    function automatic int exp_count(input logic [WIDTH-1:0] w);
        int n = 0;
        bit have = 1'b1;
        bit last = 1'b0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (have && w[b] == last) begin
                n++; have = 1'b0;
            end else begin
                have = 1'b1; last = w[b];
            end
        end
        return n;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int off = 0; off < NREQ; off++)
            if (m[(p + off) % NREQ]) return (p + off) % NREQ;
        return -1;
    endfunction

    task automatic wait_grant(output int gcyc, output int gid);
        gcyc = -1;
        gid  = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != 0) begin
                gcyc = cyc;
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) gid = j;
                if (!$onehot(req_ready)) gid = -2;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic follow(input int gid, input bit drop, output bit ok,
                          output logic [WIDTH-1:0] sh, output int lat,
                          output int rid, output int rcnt, output bit rdy);
        ok = 1'b1; rdy = 1'b0; lat = -1; sh = '0; rid = -1; rcnt = -1;
        @(negedge clk);
        if (drop && gid >= 0) req_valid[gid] = 1'b0;
        #1;
        if (det_clr !== 1'b1 || det_inp !== 1'b0) ok = 1'b0;
        if (req_ready != 0) rdy = 1'b1;
        for (int b = 0; b < WIDTH; b++) begin
            @(negedge clk); #1;
            sh[WIDTH-1-b] = det_inp;
            if (det_clr !== 1'b0) ok = 1'b0;
            if (req_ready != 0) rdy = 1'b1;
        end
        for (int i = WIDTH + 2; i < 60; i++) begin
            @(negedge clk); #1;
            if (req_ready != 0) rdy = 1'b1;
            if (res_valid === 1'b1) begin
                lat = i; rid = int'(res_id); rcnt = int'(res_count);
                break;
            end
            if (det_inp !== 1'b0 || det_clr !== 1'b0) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({det_clr, det_inp, res_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000", {det_clr, det_inp, res_valid});
        end
        checks++;
        if (res_id !== '0 || res_count !== '0) begin
            errors++; $display("FAIL reset_res got id %0d cnt %0d exp 0 0", res_id, res_count);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_single();
        int g, gid, lat, rid, rcnt, e;
        bit ok, rs;
        logic [WIDTH-1:0] sh;
        @(negedge clk);
        req_data[0 +: WIDTH] = 8'h00; req_valid = 4'b0001; res_ready = 1'b1;
        wait_grant(g, gid);
        e = rr_pick(4'b0001, ptr_m); ptr_m = (e + 1) % NREQ;
        checks++;
        if (gid != e) begin errors++; $display("FAIL single_grant got %0d exp %0d", gid, e); end
        follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
        checks++;
        if (!ok || sh !== 8'h00) begin
            errors++; $display("FAIL single_serial got ok %0d bits %h exp 1 00", ok, sh);
        end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, LAT); end
        checks++;
        if (rid != 0 || rcnt != 4) begin
            errors++; $display("FAIL single_result got (%0d,%0d) exp (0,4)", rid, rcnt);
        end
        @(negedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b exp 0", res_valid); end
    endtask

    task automatic test_sequential();
        int ids [3] = '{1, 2, 3};
        logic [WIDTH-1:0] dat [3] = '{8'hFF, 8'hAA, 8'h55};
        int cnt [3] = '{4, 0, 1};
        int g, gid, lat, rid, rcnt;
        bit ok, rs;
        logic [WIDTH-1:0] sh;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            req_data[ids[n]*WIDTH +: WIDTH] = dat[n];
            req_valid = '0; req_valid[ids[n]] = 1'b1; res_ready = 1'b1;
            wait_grant(g, gid);
            ptr_m = (ids[n] + 1) % NREQ;
            checks++;
            if (gid != ids[n]) begin errors++; $display("FAIL seq_grant got %0d exp %0d", gid, ids[n]); end
            follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
            checks++;
            if (!ok || sh !== dat[n] || lat != LAT) begin
                errors++; $display("FAIL seq_serial got ok %0d bits %h lat %0d exp 1 %h %0d", ok, sh, lat, dat[n], LAT);
            end
            checks++;
            if (rid != ids[n] || rcnt != cnt[n]) begin
                errors++; $display("FAIL seq_result got (%0d,%0d) exp (%0d,%0d)", rid, rcnt, ids[n], cnt[n]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_all_valid();
        int g, gid, lat, rid, rcnt, e, pg;
        bit ok, rs;
        logic [WIDTH-1:0] sh;
        @(negedge clk);
        req_data = '0; req_valid = 4'hF; res_ready = 1'b1; pg = -1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g, gid);
            e = rr_pick(4'hF, ptr_m); ptr_m = (e + 1) % NREQ;
            checks++;
            if (gid != e) begin errors++; $display("FAIL rr_order n=%0d got %0d exp %0d", n, gid, e); end
            if (n > 0) begin
                checks++;
                if (g - pg != LAT + 1) begin
                    errors++; $display("FAIL rr_period got %0d exp %0d", g - pg, LAT + 1);
                end
            end
            pg = g;
            follow(gid, 1'b0, ok, sh, lat, rid, rcnt, rs);
            if (n == 4) req_valid = '0;
            checks++;
            if (rs || rid != e || rcnt != 4) begin
                errors++; $display("FAIL rr_result got busy_ready %0d (%0d,%0d) exp 0 (%0d,4)", rs, rid, rcnt, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int g, gid, lat, rid, rcnt, e;
        bit ok, rs;
        logic [WIDTH-1:0] sh, d, d1;
        logic [NREQ-1:0] em;
        d = WIDTH'($urandom); d1 = WIDTH'($urandom);
        @(negedge clk);
        req_data[2*WIDTH +: WIDTH] = d; req_valid = 4'b0100; res_ready = 1'b0;
        wait_grant(g, gid);
        e = rr_pick(4'b0100, ptr_m); ptr_m = (e + 1) % NREQ;
        follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
        checks++;
        if (gid != e || rid != e || rcnt != exp_count(d) || lat != LAT) begin
            errors++; $display("FAIL bp_result got g%0d (%0d,%0d) lat %0d exp g%0d (%0d,%0d) lat %0d", gid, rid, rcnt, lat, e, e, exp_count(d), LAT);
        end
        req_data[1*WIDTH +: WIDTH] = d1; req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || int'(res_id) != rid || int'(res_count) != rcnt || req_ready !== '0) begin
                errors++; $display("FAIL bp_hold got v%b (%0d,%0d) rdy %b exp v1 (%0d,%0d) rdy 0", res_valid, res_id, res_count, req_ready, rid, rcnt);
            end
        end
        res_ready = 1'b1;
        @(negedge clk); #1;
        e = rr_pick(4'b0010, ptr_m); em = '0; em[e] = 1'b1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== em) begin
            errors++; $display("FAIL bp_release got v%b rdy %b exp v0 rdy %b", res_valid, req_ready, em);
        end
        wait_grant(g, gid);
        ptr_m = (e + 1) % NREQ;
        follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
        checks++;
        if (rid != 1 || rcnt != exp_count(d1)) begin
            errors++; $display("FAIL bp_next got (%0d,%0d) exp (1,%0d)", rid, rcnt, exp_count(d1));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int g, gid, lat, rid, rcnt, e;
        bit ok, rs, seen;
        logic [WIDTH-1:0] sh;
        @(negedge clk);
        req_data[0 +: WIDTH] = 8'hFF; req_valid = 4'b0001; res_ready = 1'b1;
        wait_grant(g, gid);
        ptr_m = (rr_pick(4'b0001, ptr_m) + 1) % NREQ;
        @(negedge clk); req_valid = '0;
        repeat (4) @(negedge clk);
        #1; rst = 1'b1; #1;
        checks++;
        if ({det_clr, det_inp, res_valid} !== 3'b000 || res_id !== '0 || res_count !== '0) begin
            errors++; $display("FAIL midrst_outputs got %b id %0d cnt %0d exp 000 0 0", {det_clr, det_inp, res_valid}, res_id, res_count);
        end
        ptr_m = 0;
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (res_valid !== 1'b0 || det_clr !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_quiet got activity 1 exp 0"); end
        req_data[2*WIDTH +: WIDTH] = 8'hFF; req_valid = 4'b0100;
        wait_grant(g, gid);
        e = rr_pick(4'b0100, ptr_m); ptr_m = (e + 1) % NREQ;
        follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
        checks++;
        if (gid != 2 || rid != 2 || rcnt != 4) begin
            errors++; $display("FAIL midrst_next got g%0d (%0d,%0d) exp g2 (2,4)", gid, rid, rcnt);
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        int g, gid, lat, rid, rcnt, e;
        bit ok, rs, seen;
        logic [WIDTH-1:0] sh, d3;
        d3 = WIDTH'($urandom);
        @(negedge clk);
        req_data[0 +: WIDTH] = WIDTH'($urandom); req_valid = 4'b0001; res_ready = 1'b1;
        wait_grant(g, gid);
        ptr_m = (rr_pick(4'b0001, ptr_m) + 1) % NREQ;
        req_data[3*WIDTH +: WIDTH] = d3; req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
        checks++;
        if (rs) begin errors++; $display("FAIL drop_busy_ready got 1 exp 0"); end
        req_valid[1] = 1'b0;
        wait_grant(g, gid);
        e = rr_pick(4'b1000, ptr_m); ptr_m = (e + 1) % NREQ;
        checks++;
        if (gid != e) begin errors++; $display("FAIL drop_grant got %0d exp %0d", gid, e); end
        follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
        checks++;
        if (rid != 3 || rcnt != exp_count(d3)) begin
            errors++; $display("FAIL drop_result got (%0d,%0d) exp (3,%0d)", rid, rcnt, exp_count(d3));
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (i > 0 && (res_valid !== 1'b0 || req_ready !== '0)) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL drop_ghost got activity 1 exp 0"); end
    endtask

    task automatic test_random();
        int g, gid, lat, rid, rcnt, e;
        bit ok, rs, rr;
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] dv [NREQ];
        logic [NREQ-1:0] m;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) begin
                dv[j] = WIDTH'($urandom);
                req_data[j*WIDTH +: WIDTH] = dv[j];
            end
            rr = 1'($urandom % 2);
            req_valid = m; res_ready = rr;
            wait_grant(g, gid);
            e = rr_pick(m, ptr_m); ptr_m = (e + 1) % NREQ;
            checks++;
            if (gid != e) begin errors++; $display("FAIL rnd_grant n=%0d got %0d exp %0d", n, gid, e); end
            follow(gid, 1'b1, ok, sh, lat, rid, rcnt, rs);
            req_valid = '0;
            checks++;
            if (!ok || rs || sh !== dv[e] || lat != LAT) begin
                errors++; $display("FAIL rnd_serial n=%0d got ok%0d rdy%0d %h lat %0d exp 1 0 %h %0d", n, ok, rs, sh, lat, dv[e], LAT);
            end
            checks++;
            if (rid != e || rcnt != exp_count(dv[e])) begin
                errors++; $display("FAIL rnd_result n=%0d got (%0d,%0d) exp (%0d,%0d)", n, rid, rcnt, e, exp_count(dv[e]));
            end
            if (!rr) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1; res_ready = 1'b1;
            end
            @(negedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL rnd_release got 1 exp 0"); end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_sequential();
        test_all_valid();
        test_backpressure();
        test_reset_mid();
        test_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one bit-serial sequence detector among NREQ requesters. Each requester submits a WIDTH-bit word with a valid/ready handshake. The scheduler grants one requester and clears the detector. It then shifts the word in MSB first, counts the detector's hit pulses, and returns the count tagged with the requester id. It sits between the requester ports and the single detector instance, and is the only driver of that detector.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, bits per submitted word (1..32)
- DET_LAT, 2, cycles from det_inp bit to its det_outp response
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*WIDTH  words; requester i at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot accept strobe (combinational)
- det_clr  out  1  registered clear to detector reset input
- det_inp  out  1  registered serial bit to detector
- det_outp  in  1  detector hit output
- res_valid  out  1  result valid
- res_id  out  max(1,$clog2(NREQ))  requester id of result
- res_count  out  $clog2(WIDTH+1)  hit count
- res_ready  in  1  result consumer ready

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, RESULT.
- IDLE: if any req_valid is set, the winner is the first set bit searching upward (wrapping) from ptr. req_ready[winner]=1 that cycle only. Latch the word, id=winner, ptr=winner+1 mod NREQ, go to CLEAR. With no request, stay in IDLE.
- req_ready is 0 in every state except IDLE, and is at most one-hot.
- CLEAR: det_clr=1 for exactly one cycle. The bit counter and hit counter are zeroed. Go to SHIFT.
- SHIFT: WIDTH cycles. det_inp = word bit WIDTH-1-k in SHIFT cycle k. Go to DRAIN.
- DRAIN: DET_LAT cycles, det_inp=0. Go to RESULT.
- Hit sampling: count det_outp in SHIFT cycles with k>=DET_LAT and in all DRAIN cycles. That is exactly WIDTH samples, one per shifted bit. Samples in CLEAR and in SHIFT k<DET_LAT are ignored.
- res_count saturates at WIDTH; it cannot exceed WIDTH by construction.
- RESULT: res_valid=1. res_id and res_count are held stable until res_ready=1. The cycle of res_valid&res_ready transfers the result; next state is IDLE.
- req_valid deasserting while not granted has no effect. req_data is sampled only in the grant cycle.
- Reset (any time, including mid-SHIFT): state=IDLE, ptr=0, det_clr=0, det_inp=0, res_valid=0, res_id=0, res_count=0. An in-flight word is dropped and no result is produced. The detector shares rst and is therefore also reset.

## Timing
- Grant cycle T0. CLEAR at T0+1. SHIFT from T0+2 to T0+1+WIDTH.
- DRAIN from T0+2+WIDTH to T0+1+WIDTH+DET_LAT.
- res_valid is first high at T0+2+WIDTH+DET_LAT (WIDTH=8, DET_LAT=2: T0+12).
- The next grant is no earlier than the cycle after the result handshake. Minimum period is WIDTH+DET_LAT+3 cycles per word.
- det_clr and det_inp change only on clk edges.
- res_ready asserted before res_valid has no effect.

## Test plan
All scenarios use WIDTH=8 and DET_LAT=2, with the team's bit-serial sequence detector attached. Per the detector's transition behaviour, the expected hit counts are 0x00→4, 0xFF→4, 0xAA→0, 0x55→1.
- Single requester 0, data 0x00, res_ready=1 -> grant at T0, res_valid at T0+12, res_id=0, res_count=4.
- Requesters 1/2/3 submit 0xFF/0xAA/0x55 sequentially -> results (1,4), (2,0), (3,1).
- All four req_valid held high with 0x00 -> grant order 0,1,2,3,0. req_ready is one-hot and is asserted only in IDLE.
- Result with res_ready=0 for 5 cycles -> res_valid stays high, res_id/res_count stay stable, no new grant. Release -> one transfer, then IDLE.
- rst pulse at SHIFT cycle 3 -> all outputs at reset values. The next request (id 2, 0xFF) is granted with ptr=0 search and yields (2,4).
- req_valid on requester 1 dropped before grant while requester 3 is valid -> requester 3 is granted, and no result is ever produced for id 1.
